// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU control codes and the
// arbiter FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from the requester after
// last_grant and returns a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx
);

    logic            found;
    int              cand;
    logic [IDXW-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        // Walk the ring once, starting just past the previous winner.
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(last_grant) + k) % NREQ;
            cand_idx = IDXW'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin grant,
// one operation in flight, registered result returned on a valid/ready channel.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       ReqValid,
    output logic [NREQ-1:0]       ReqReady,
    input  logic [NREQ*WIDTH-1:0] ReqBusA,
    input  logic [NREQ*WIDTH-1:0] ReqBusB,
    input  logic [NREQ*4-1:0]     ReqCtrl,
    output logic [WIDTH-1:0]      AluBusA,
    output logic [WIDTH-1:0]      AluBusB,
    output logic [3:0]            AluCtrl,
    input  logic [WIDTH-1:0]      AluBusW,
    input  logic                  AluZero,
    output logic [NREQ-1:0]       RespValid,
    input  logic [NREQ-1:0]       RespReady,
    output logic [WIDTH-1:0]      RespBusW,
    output logic                  RespZero
);

    localparam int IDXW = $clog2(NREQ);

    arb_state_t       state_q, state_d;
    logic [IDXW-1:0]  last_grant_q, last_grant_d;
    logic [IDXW-1:0]  op_idx_q, op_idx_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [3:0]       op_ctrl_q, op_ctrl_d;
    logic [WIDTH-1:0] resp_w_q, resp_w_d;
    logic             resp_zero_q, resp_zero_d;

    logic [NREQ-1:0]  grant;
    logic [IDXW-1:0]  grant_idx;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_arbiter (
        .req        (ReqValid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDXW'(NREQ - 1);
            op_idx_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_ctrl_q    <= '0;
            resp_w_q     <= '0;
            resp_zero_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_idx_q     <= op_idx_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_ctrl_q    <= op_ctrl_d;
            resp_w_q     <= resp_w_d;
            resp_zero_q  <= resp_zero_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_idx_d     = op_idx_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_ctrl_d    = op_ctrl_q;
        resp_w_d     = resp_w_q;
        resp_zero_d  = resp_zero_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    op_idx_d = grant_idx;
                    for (int i = 0; i < NREQ; i++) begin
                        if (grant[i]) begin
                            op_a_d    = ReqBusA[i*WIDTH +: WIDTH];
                            op_b_d    = ReqBusB[i*WIDTH +: WIDTH];
                            op_ctrl_d = ReqCtrl[i*4 +: 4];
                        end
                    end
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                resp_w_d    = AluBusW;
                resp_zero_d = AluZero;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                // Only the owner of the in-flight op can complete it.
                if (RespReady[op_idx_q]) begin
                    last_grant_d = op_idx_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ReqReady  = '0;
        RespValid = '0;
        AluBusA   = '0;
        AluBusB   = '0;
        AluCtrl   = ALU_AND;
        unique case (state_q)
            ST_IDLE: begin
                if (!Reset) ReqReady = grant;
            end
            ST_EXEC: begin
                AluBusA = op_a_q;
                AluBusB = op_b_q;
                AluCtrl = op_ctrl_q;
            end
            ST_RESP: begin
                if (!Reset) RespValid[op_idx_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign RespBusW = resp_w_q;
    assign RespZero = resp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: behavioural ALU behind the DUT,
// transaction-level model checked every cycle, plus directed literal checks.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid, req_ready;
    logic [127:0] req_a, req_b;
    logic [7:0]   req_ctrl;
    logic [63:0]  alu_a, alu_b, alu_w;
    logic [3:0]   alu_ctrl;
    logic         alu_zero;
    logic [1:0]   resp_valid, resp_ready;
    logic [63:0]  resp_w;
    logic         resp_zero;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          acc_idx[$];
    int          acc_cyc[$];
    int          rsp_idx[$];
    logic [63:0] rsp_w[$];
    logic        rsp_z[$];

    bit          m_busy = 1'b0;
    int          m_age  = 0;
    int          m_idx  = 0;
    int          m_last = 1;
    logic [63:0] m_a, m_b, m_w;
    logic [3:0]  m_c;
    logic        m_z;

    alu_share_arbiter #(.NREQ(2), .WIDTH(64)) dut (
        .CLK       (clk),
        .Reset     (rst),
        .ReqValid  (req_valid),
        .ReqReady  (req_ready),
        .ReqBusA   (req_a),
        .ReqBusB   (req_b),
        .ReqCtrl   (req_ctrl),
        .AluBusA   (alu_a),
        .AluBusB   (alu_b),
        .AluCtrl   (alu_ctrl),
        .AluBusW   (alu_w),
        .AluZero   (alu_zero),
        .RespValid (resp_valid),
        .RespReady (resp_ready),
        .RespBusW  (resp_w),
        .RespZero  (resp_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b,
                                           input logic [3:0] c);
        case (c)
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_PASSB: return b;
            default:   return 64'd0;
        endcase
    endfunction

    always_comb begin
        alu_w    = alu_fn(alu_a, alu_b, alu_ctrl);
        alu_zero = (alu_w == 64'd0);
    end

    function automatic logic [1:0] rr_expect(input logic [1:0] v, input int last);
        logic [1:0] r;
        r = 2'b00;
        for (int k = 1; k <= 2; k++) begin
            if (r == 2'b00 && v[(last + k) % 2]) r[(last + k) % 2] = 1'b1;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle monitor and transaction-level model.
    always @(negedge clk) begin
        logic [1:0] exp_grant;
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                acc_idx.push_back(i);
                acc_cyc.push_back(cyc);
            end
            if (resp_valid[i] && resp_ready[i]) begin
                rsp_idx.push_back(i);
                rsp_w.push_back(resp_w);
                rsp_z.push_back(resp_zero);
            end
        end
        if (rst) begin
            checkOutput("m_rst_req_ready", 64'(req_ready), 64'd0);
            checkOutput("m_rst_resp_valid", 64'(resp_valid), 64'd0);
            m_busy = 1'b0;
            m_last = 1;
        end else if (!m_busy) begin
            exp_grant = rr_expect(req_valid, m_last);
            checkOutput("m_idle_req_ready", 64'(req_ready), 64'(exp_grant));
            checkOutput("m_idle_resp_valid", 64'(resp_valid), 64'd0);
            checkOutput("m_idle_alu_a", alu_a, 64'd0);
            checkOutput("m_idle_alu_ctrl", 64'(alu_ctrl), 64'd0);
            if (exp_grant != 2'b00) begin
                m_idx  = exp_grant[1] ? 1 : 0;
                m_a    = req_a[m_idx*64 +: 64];
                m_b    = req_b[m_idx*64 +: 64];
                m_c    = req_ctrl[m_idx*4 +: 4];
                m_busy = 1'b1;
                m_age  = 1;
            end
        end else if (m_age == 1) begin
            checkOutput("m_exec_req_ready", 64'(req_ready), 64'd0);
            checkOutput("m_exec_resp_valid", 64'(resp_valid), 64'd0);
            checkOutput("m_exec_alu_a", alu_a, m_a);
            checkOutput("m_exec_alu_b", alu_b, m_b);
            checkOutput("m_exec_alu_ctrl", 64'(alu_ctrl), 64'(m_c));
            m_w   = alu_fn(m_a, m_b, m_c);
            m_z   = (m_w == 64'd0);
            m_age = 2;
        end else begin
            checkOutput("m_resp_req_ready", 64'(req_ready), 64'd0);
            checkOutput("m_resp_valid", 64'(resp_valid), 64'(2'b01 << m_idx));
            checkOutput("m_resp_w", resp_w, m_w);
            checkOutput("m_resp_zero", 64'(resp_zero), 64'(m_z));
            checkOutput("m_resp_alu_b", alu_b, 64'd0);
            if (resp_ready[m_idx]) begin
                m_busy = 1'b0;
                m_last = m_idx;
            end
        end
    end

    task automatic applyStimulus(input int idx, input logic [3:0] ctrl,
                                 input logic [63:0] a, input logic [63:0] b);
        int base, n;
        base = acc_idx.size();
        req_a[idx*64 +: 64]  = a;
        req_b[idx*64 +: 64]  = b;
        req_ctrl[idx*4 +: 4] = ctrl;
        req_valid[idx]       = 1'b1;
        n = 0;
        while (acc_idx.size() == base && n < 50) begin
            tick();
            n++;
        end
        if (acc_idx.size() == base) checkOutput("accept_timeout", 64'd0, 64'd1);
        req_valid[idx] = 1'b0;
    endtask

    task automatic waitResp(input int target);
        int n;
        n = 0;
        while (rsp_idx.size() < target && n < 50) begin
            tick();
            n++;
        end
        if (rsp_idx.size() < target) checkOutput("resp_timeout", 64'(rsp_idx.size()), 64'(target));
    endtask

    task automatic checkResp(input int k, input string name, input int idx,
                             input logic [63:0] w, input logic z);
        if (k < rsp_idx.size()) begin
            checkOutput({name, "_idx"}, 64'(rsp_idx[k]), 64'(idx));
            checkOutput({name, "_w"}, rsp_w[k], w);
            checkOutput({name, "_zero"}, 64'(rsp_z[k]), 64'(z));
        end else begin
            checkOutput({name, "_missing"}, 64'(rsp_idx.size()), 64'(k + 1));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_acc, base_rsp, p, cnt0, cnt1, n, e, k;
        rst        = 1'b1;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req_a      = '0;
        req_b      = '0;
        req_ctrl   = '0;
        repeat (3) tick();
        checkOutput("reset_resp_w", resp_w, 64'd0);
        checkOutput("reset_resp_zero", 64'(resp_zero), 64'd0);
        checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        rst        = 1'b0;
        resp_ready = 2'b11;

        // Single ops on each requester, including an unsupported control code.
        applyStimulus(0, ALU_ADD, 64'd5, 64'd7);
        waitResp(1);
        checkResp(0, "add", 0, 64'd12, 1'b0);
        checkOutput("add_latency", 64'(rsp_idx.size() > 0 ? 2 : 0), 64'd2);
        applyStimulus(0, 4'b1111, 64'd3, 64'd4);
        waitResp(2);
        checkResp(1, "bad_ctrl", 0, 64'd0, 1'b1);
        applyStimulus(1, ALU_SUB, 64'd9, 64'd9);
        waitResp(3);
        checkResp(2, "sub", 1, 64'd0, 1'b1);
        applyStimulus(1, ALU_PASSB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        waitResp(4);
        checkResp(3, "passb", 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Both requesters contending, operands change after every accept.
        base_acc = acc_idx.size();
        base_rsp = rsp_idx.size();
        cnt0 = 0;
        cnt1 = 0;
        p    = 0;
        req_a[63:0] = 64'd1000;  req_b[63:0] = 64'd0;  req_ctrl[3:0] = ALU_ADD;
        req_a[127:64] = 64'd500; req_b[127:64] = 64'd1; req_ctrl[7:4] = ALU_SUB;
        req_valid = 2'b11;
        n = 0;
        while ((cnt0 < 4 || cnt1 < 4) && n < 200) begin
            tick();
            n++;
            while (acc_idx.size() > base_acc + p) begin
                e = acc_idx[base_acc + p];
                p++;
                if (e == 0) begin
                    cnt0++;
                    if (cnt0 < 4) begin
                        req_a[63:0] = 64'(1000 + cnt0);
                        req_b[63:0] = 64'(cnt0 * cnt0);
                    end else req_valid[0] = 1'b0;
                end else begin
                    cnt1++;
                    if (cnt1 < 4) begin
                        req_a[127:64] = 64'(500 * (cnt1 + 1));
                        req_b[127:64] = 64'(cnt1 + 1);
                    end else req_valid[1] = 1'b0;
                end
            end
        end
        req_valid = 2'b00;
        if (cnt0 < 4 || cnt1 < 4) checkOutput("rr_accept_timeout", 64'(cnt0 + cnt1), 64'd8);
        waitResp(base_rsp + 8);
        for (int j = 0; j < 8; j++) begin
            k = j / 2;
            if (j % 2 == 0) checkResp(base_rsp + j, "rr_req0", 0, 64'(1000 + k + k * k), 1'b0);
            else            checkResp(base_rsp + j, "rr_req1", 1, 64'(499 * (k + 1)), 1'b0);
            if (j > 0 && base_acc + j < acc_cyc.size())
                checkOutput("rr_spacing", 64'(acc_cyc[base_acc + j] - acc_cyc[base_acc + j - 1]), 64'd3);
        end

        // Response stall on requester 0 while requester 1 is waiting.
        base_acc   = acc_idx.size();
        base_rsp   = rsp_idx.size();
        resp_ready = 2'b10;
        applyStimulus(0, ALU_ADD, 64'd1, 64'd2);
        req_a[127:64] = 64'd10; req_b[127:64] = 64'd20; req_ctrl[7:4] = ALU_ADD;
        req_valid = 2'b11;
        n = 0;
        while (resp_valid[0] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        repeat (5) begin
            checkOutput("stall_resp_valid", 64'(resp_valid), 64'd1);
            checkOutput("stall_resp_w", resp_w, 64'd3);
            checkOutput("stall_resp_zero", 64'(resp_zero), 64'd0);
            checkOutput("stall_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        checkOutput("stall_no_grant", 64'(acc_idx.size()), 64'(base_acc + 1));
        resp_ready = 2'b11;
        n = 0;
        while (acc_idx.size() < base_acc + 2 && n < 20) begin
            tick();
            n++;
        end
        req_valid = 2'b00;
        checkOutput("stall_next_grant", 64'(acc_idx.size() >= base_acc + 2 ? acc_idx[base_acc + 1] : 99), 64'd1);
        waitResp(base_rsp + 2);
        checkResp(base_rsp, "stall_op0", 0, 64'd3, 1'b0);
        checkResp(base_rsp + 1, "stall_op1", 1, 64'd30, 1'b0);

        // Reset while an op is executing: op is lost, requester 0 wins next.
        base_rsp = rsp_idx.size();
        applyStimulus(0, ALU_ADD, 64'd40, 64'd2);
        rst = 1'b1;
        tick();
        checkOutput("exec_rst_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("exec_rst_resp_w", resp_w, 64'd0);
        checkOutput("exec_rst_resp_zero", 64'(resp_zero), 64'd0);
        rst = 1'b0;
        repeat (4) tick();
        checkOutput("exec_rst_no_resp", 64'(rsp_idx.size()), 64'(base_rsp));
        base_acc = acc_idx.size();
        req_a[63:0]   = 64'd1; req_b[63:0]   = 64'd1; req_ctrl[3:0] = ALU_ADD;
        req_a[127:64] = 64'd2; req_b[127:64] = 64'd2; req_ctrl[7:4] = ALU_ADD;
        req_valid = 2'b11;
        n = 0;
        while (acc_idx.size() == base_acc && n < 20) begin
            tick();
            n++;
        end
        req_valid = 2'b00;
        checkOutput("post_rst_grant", 64'(acc_idx.size() > base_acc ? acc_idx[base_acc] : 99), 64'd0);
        waitResp(base_rsp + 1);
        checkResp(base_rsp, "post_rst_op", 0, 64'd2, 1'b0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
